cache_i_sa: RTL and testbench



---
 rtl/cache_i_sa_pkg.sv | 28 ++
 rtl/cache_i_way.sv | 72 +++++++
 rtl/cache_i_sa.sv | 175 +++++++++++++++++
 tb/tb_cache_i_sa.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_i_sa_pkg.sv
// ============================================================================
// Module : cache_i_sa_pkg
// Brief  : Shared defaults, derived widths and FSM states for the I-cache.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_i_sa_pkg;

    localparam int ICacheSetBits    = 6;
    localparam int ICacheLineWords  = 2;
    localparam int ICacheWays       = 2;
    localparam int ICacheOffsetBits = $clog2(4 * ICacheLineWords);
    localparam int ICacheIndexBits  = ICacheSetBits;
    localparam int ICacheTagBits    = 32 - ICacheOffsetBits - ICacheIndexBits;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_e;

    function automatic int ic_offset_bits(input int line_words);
        return $clog2(4 * line_words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_i_way.sv
// ============================================================================
// Module : cache_i_way
// Brief  : One cache way: valid/tag/data arrays, async read, sync line write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_i_way #(
    parameter int SET_BITS   = 6,
    parameter int TAG_W      = 23,
    parameter int LINE_WORDS = 2,
    parameter int WSEL_W     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [SET_BITS-1:0]      rd_index_i,
    input  logic [TAG_W-1:0]         rd_tag_i,
    input  logic [WSEL_W-1:0]        rd_wsel_i,
    output logic                     hit_o,
    output logic                     valid_o,
    output logic [31:0]              word_o,
    input  logic                     wr_en_i,
    input  logic                     wr_valid_i,
    input  logic [SET_BITS-1:0]      wr_index_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic [LINE_WORDS*32-1:0] wr_line_i
);

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]              valid_q;
    logic [TAG_W-1:0]             tag_q  [SETS];
    logic [LINE_WORDS-1:0][31:0]  data_q [SETS];
    logic [LINE_WORDS-1:0][31:0]  rd_line;
    logic                         rd_valid;

    assign rd_line  = data_q[rd_index_i];
    assign rd_valid = valid_q[rd_index_i];
    assign valid_o  = rd_valid;
    assign hit_o    = rd_valid && (tag_q[rd_index_i] == rd_tag_i);

    generate
        if (LINE_WORDS > 1) begin : g_word_sel
            assign word_o = rd_line[rd_wsel_i];
        end else begin : g_word_single
            logic unused_wsel;
            assign unused_wsel = ^rd_wsel_i;
            assign word_o      = rd_line[0];
        end
    endgenerate

    // A fill landing on a flush edge keeps its own valid value (the top forces 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (flush_i) valid_q <= '0;
            if (wr_en_i) valid_q[wr_index_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_i_sa.sv
// ============================================================================
// Module : cache_i_sa
// Brief  : Set-associative I-cache with byte-serial refill, LRU and flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_i_sa
    import cache_i_sa_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SET_BITS   = ICacheSetBits,
    parameter int LINE_WORDS = ICacheLineWords,
    parameter int WAYS       = ICacheWays
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  request_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [31:0]           data_o,
    output logic                  done_o,
    output logic                  request_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic [7:0]            data_i,
    input  logic                  done_i
);

    localparam int LINE_BYTES = 4 * LINE_WORDS;
    localparam int OFF_W      = ic_offset_bits(LINE_WORDS);
    localparam int TAG_W      = ADDR_WIDTH - OFF_W - SET_BITS;
    localparam int WSEL_W     = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int SETS       = 1 << SET_BITS;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_BYTES - 1);
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);

    logic [SET_BITS-1:0] rd_index;
    logic [TAG_W-1:0]    rd_tag;
    logic [WSEL_W-1:0]   rd_wsel;
    logic [1:0]          unused_addr_lsb;

    assign rd_index        = addr_i[OFF_W +: SET_BITS];
    assign rd_tag          = addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign unused_addr_lsb = addr_i[1:0];

    generate
        if (LINE_WORDS > 1) begin : g_wsel
            assign rd_wsel = addr_i[2 +: WSEL_W];
        end else begin : g_wsel_none
            assign rd_wsel = '0;
        end
    endgenerate

    ic_state_e                        state_q;
    logic [ADDR_WIDTH-OFF_W-1:0]      base_q;
    logic [OFF_W-1:0]                 cnt_q;
    logic [LINE_BYTES-2:0][7:0]       buf_q;
    logic                             victim_q;
    logic                             flush_pend_q;
    logic [SETS-1:0]                  lru_q;

    logic [WAYS-1:0] way_hit;
    logic [WAYS-1:0] way_vld;
    logic [31:0]     way_word [WAYS];
    logic            hit_any;
    logic            hit_way;
    logic [31:0]     hit_word;
    logic            lookup_hit;
    logic            victim_sel;
    logic            fill;
    logic            fill_valid;
    logic [LINE_BYTES*8-1:0] fill_line;

    assign fill       = (state_q == IC_REFILL) && done_i && (cnt_q == CNT_LAST);
    assign fill_valid = !(flush_pend_q || flush_i);
    assign fill_line  = {data_i, buf_q};

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            cache_i_way #(
                .SET_BITS   (SET_BITS),
                .TAG_W      (TAG_W),
                .LINE_WORDS (LINE_WORDS),
                .WSEL_W     (WSEL_W)
            ) u_way (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush_i    (flush_i),
                .rd_index_i (rd_index),
                .rd_tag_i   (rd_tag),
                .rd_wsel_i  (rd_wsel),
                .hit_o      (way_hit[g]),
                .valid_o    (way_vld[g]),
                .word_o     (way_word[g]),
                .wr_en_i    (fill && (victim_q == 1'(g))),
                .wr_valid_i (fill_valid),
                .wr_index_i (base_q[SET_BITS-1:0]),
                .wr_tag_i   (base_q[ADDR_WIDTH-OFF_W-1 -: TAG_W]),
                .wr_line_i  (fill_line)
            );
        end
    endgenerate

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = 1'b0;
        hit_word = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_any  = 1'b1;
                hit_way  = w[0];
                hit_word = way_word[w];
            end
        end
    end

    // Invalid ways are filled first (way 0 priority), then the LRU way.
    always_comb begin
        victim_sel = 1'b0;
        if (WAYS > 1) begin
            if (!way_vld[0])             victim_sel = 1'b0;
            else if (!way_vld[WAYS-1])   victim_sel = 1'b1;
            else                         victim_sel = lru_q[rd_index];
        end
    end

    assign lookup_hit = hit_any && !flush_i;
    assign done_o     = !request_i || lookup_hit;
    assign data_o     = (request_i && lookup_hit) ? hit_word : '0;
    assign request_o  = (state_q == IC_REFILL);
    assign addr_o     = request_o ? {base_q, cnt_q} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IC_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            buf_q        <= '0;
            victim_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            lru_q        <= '0;
        end else begin
            if (lookup_hit && request_i) lru_q[rd_index] <= ~hit_way;
            case (state_q)
                IC_IDLE: begin
                    if (request_i && !hit_any && !flush_i) begin
                        state_q      <= IC_REFILL;
                        base_q       <= addr_i[ADDR_WIDTH-1:OFF_W];
                        victim_q     <= victim_sel;
                        cnt_q        <= '0;
                        flush_pend_q <= 1'b0;
                    end
                end
                IC_REFILL: begin
                    if (flush_i) flush_pend_q <= 1'b1;
                    if (done_i) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q             <= IC_IDLE;
                            cnt_q               <= '0;
                            flush_pend_q        <= 1'b0;
                            lru_q[base_q[SET_BITS-1:0]] <= ~victim_q;
                        end else begin
                            buf_q[cnt_q] <= data_i;
                            cnt_q        <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_q <= IC_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_i_sa.sv
// ============================================================================
// Module : tb_cache_i_sa
// Brief  : Directed self-checking bench for cache_i_sa (64 sets, 2 words, 2 ways).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_i_sa;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        request_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_o;
    logic        done_o;
    logic        request_o;
    logic [31:0] addr_o;
    logic [7:0]  data_i = '0;
    logic        done_i = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc;

    always #5 clk = ~clk;

    cache_i_sa #(
        .ADDR_WIDTH (32),
        .SET_BITS   (6),
        .LINE_WORDS (2),
        .WAYS       (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .request_i (request_i),
        .addr_i    (addr_i),
        .data_o    (data_o),
        .done_o    (done_o),
        .request_o (request_o),
        .addr_o    (addr_o),
        .data_i    (data_i),
        .done_i    (done_i)
    );

    // Memory image: byte = 0x11*(offset+1) xor (a few address bits << 4).
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [3:0] key;
        logic [7:0] b;
        key = {a[16], a[15], a[10], a[9]};
        b   = 8'({5'd0, a[2:0]} + 8'd1) * 8'h11;
        return b ^ {key, 4'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input logic exp_done,
                         input logic [31:0] exp_data, input bit hold);
        request_i = 1'b1;
        addr_i    = a;
        #1;
        check({tag, "_done"}, done_o, exp_done);
        check({tag, "_data"}, data_o, exp_data);
        if (hold) tick();
        request_i = 1'b0;
    endtask

    task automatic miss_start(input string tag, input logic [31:0] a);
        request_i = 1'b1;
        addr_i    = a;
        #1;
        check({tag, "_miss_done"}, done_o, 1'b0);
        check({tag, "_miss_data"}, data_o, 32'h0);
        tick();
    endtask

    task automatic serve(input string tag, input logic [31:0] base, input int nbeats,
                         input bit stall, input int flush_at, input int alt_at,
                         input logic [31:0] alt_addr, input logic [31:0] alt_exp,
                         output int cycles);
        int  beat = 0;
        int  c    = 0;
        bit  fl_done  = 0;
        bit  alt_done = 0;
        bit  alt_now;
        while (beat < nbeats && c < 200) begin
            done_i  = stall ? (c % 3 == 0) : 1'b1;
            data_i  = done_i ? mem_byte(base + 32'(beat)) : 8'h00;
            flush_i = (beat == flush_at) && !fl_done;
            if (flush_i) fl_done = 1;
            alt_now = (beat == alt_at) && !alt_done;
            if (alt_now) alt_done = 1;
            addr_i  = alt_now ? alt_addr : base;
            #1;
            check({tag, "_req"},  request_o, 1'b1);
            check({tag, "_addr"}, addr_o, base + 32'(beat));
            if (alt_now) begin
                check({tag, "_hu_done"}, done_o, 1'b1);
                check({tag, "_hu_data"}, data_o, alt_exp);
            end else begin
                check({tag, "_stall_done"}, done_o, 1'b0);
            end
            tick();
            flush_i = 1'b0;
            if (done_i) beat++;
            c++;
        end
        check({tag, "_timeout"}, 32'(c < 200), 32'd1);
        done_i    = 1'b0;
        data_i    = 8'h00;
        addr_i    = base;
        request_i = 1'b0;
        cycles    = c;
    endtask

    initial begin
        // Reset values
        #3;
        check("rst_request_o", request_o, 1'b0);
        check("rst_addr_o",    addr_o,    32'h0);
        check("rst_done_o",    done_o,    1'b1);
        check("rst_data_o",    data_o,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Cold miss on 0x100, back-to-back beats
        miss_start("cold", 32'h100);
        serve("cold", 32'h100, 8, 0, -1, -1, 32'h0, 32'h0, cyc);
        check("cold_latency", 32'(cyc + 1), 32'd9);
        check("cold_req_low", request_o, 1'b0);
        probe("cold_hit0", 32'h100, 1'b1, 32'h44332211, 1);
        probe("cold_hit1", 32'h104, 1'b1, 32'h88776655, 1);

        // Conflict / LRU in set 32
        miss_start("c8100", 32'h8100);
        serve("c8100", 32'h8100, 8, 0, -1, -1, 32'h0, 32'h0, cyc);
        probe("c8100_hit0", 32'h8100, 1'b1, 32'h04736251, 1);
        probe("c8100_hit1", 32'h8104, 1'b1, 32'hC8372615, 1);
        probe("touch100",   32'h100,  1'b1, 32'h44332211, 1);
        miss_start("c10100", 32'h10100);
        serve("c10100", 32'h10100, 8, 0, -1, -1, 32'h0, 32'h0, cyc);
        probe("c10100_hit", 32'h10100, 1'b1, 32'hC4B3A291, 1);
        probe("lru_keep100", 32'h100,  1'b1, 32'h44332211, 1);
        probe("lru_evict8100", 32'h8100, 1'b0, 32'h0, 0);

        // Stalled memory: done_i = 1,0,0,1,0,0,...
        miss_start("stall", 32'h400);
        serve("stall", 32'h400, 8, 1, -1, -1, 32'h0, 32'h0, cyc);
        check("stall_cycles", 32'(cyc), 32'd22);
        probe("stall_hit0", 32'h400, 1'b1, 32'h64130231, 1);
        probe("stall_hit1", 32'h404, 1'b1, 32'hA8574675, 1);

        // Hit-under-refill: 0x300 evicts LRU way of set 32 (0x10100)
        miss_start("hur", 32'h300);
        serve("hur", 32'h300, 8, 0, -1, 3, 32'h100, 32'h44332211, cyc);
        probe("hur_hit0", 32'h300, 1'b1, 32'h54233201, 1);
        probe("hur_hit1", 32'h304, 1'b1, 32'h98677645, 1);
        probe("hur_keep100", 32'h100, 1'b1, 32'h44332211, 1);
        probe("hur_evicted", 32'h10100, 1'b0, 32'h0, 0);

        // Flush mid-refill of 0x200
        miss_start("fmid", 32'h200);
        serve("fmid", 32'h200, 8, 0, 3, -1, 32'h0, 32'h0, cyc);
        check("fmid_req_low", request_o, 1'b0);
        probe("fmid_200", 32'h200, 1'b0, 32'h0, 0);
        probe("fmid_100", 32'h100, 1'b0, 32'h0, 0);
        probe("fmid_400", 32'h400, 1'b0, 32'h0, 0);

        // Flush on the final beat
        miss_start("flast", 32'h100);
        serve("flast", 32'h100, 8, 0, 7, -1, 32'h0, 32'h0, cyc);
        probe("flast_100", 32'h100, 1'b0, 32'h0, 0);

        // Flush in IDLE with a miss: no refill starts
        request_i = 1'b1;
        addr_i    = 32'h100;
        flush_i   = 1'b1;
        #1;
        check("fidle_done", done_o, 1'b0);
        check("fidle_data", data_o, 32'h0);
        tick();
        flush_i   = 1'b0;
        request_i = 1'b0;
        #1;
        check("fidle_no_req", request_o, 1'b0);
        tick();

        // Reset during refill at beat 4
        miss_start("rmid", 32'h100);
        serve("rmid", 32'h100, 4, 0, -1, -1, 32'h0, 32'h0, cyc);
        check("rmid_addr_beat4", addr_o, 32'h104);
        rst_n = 1'b0;
        #1;
        check("rmid_req_drop", request_o, 1'b0);
        check("rmid_done",     done_o,    1'b1);
        check("rmid_addr",     addr_o,    32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        miss_start("rfill", 32'h100);
        serve("rfill", 32'h100, 8, 0, -1, -1, 32'h0, 32'h0, cyc);
        probe("rfill_hit0", 32'h100, 1'b1, 32'h44332211, 1);
        probe("rfill_hit1", 32'h104, 1'b1, 32'h88776655, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
